// File: rtl/rr_mux_arbiter.sv
// N-channel round-robin arbiter feeding a single registered output word.
// Reset blocks every handshake so no producer sees its word accepted while it is being discarded.
module rr_mux_arbiter #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*W-1:0]      in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                   out_ready
);

  localparam int CH_W = $clog2(N_CH);

  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_vld;
  logic            load_en;
  logic            xfer;

  assign load_en = ~out_valid | out_ready;
  assign xfer    = load_en & gnt_vld & ~rst;

  // Scan from ptr upward with wrap; the first valid channel wins.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!gnt_vld && in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*W +: W];
      out_ch    <= gnt_idx;
      ptr       <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed-vector bench for rr_mux_arbiter (N_CH=4, W=8).
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_och;
    string       name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] DSEQ = 32'h13121110;
  localparam logic [31:0] DA5  = 32'h1312A510;

  task automatic add(input logic r, input logic [3:0] iv, input logic [31:0] d,
                     input logic ordy, input logic [3:0] eir, input logic eov,
                     input logic [7:0] eod, input logic [1:0] eoch, input string nm);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.ordy = ordy;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_och = eoch; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // reset held 3 cycles under random inputs
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = 1'($urandom);
      #1 check("reset in_ready", {28'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      check("reset outs", {23'd0, out_valid, out_data, out_ch}, 32'd0);
    end

    // rst iv data ordy | in_ready  ov od ch
    add(0, 4'b0100, DSEQ, 1, 4'b0100, 1, 8'h12, 2, "first grant ch2");
    add(0, 4'b0010, DA5,  1, 4'b0010, 1, 8'hA5, 1, "single ch1");
    add(0, 4'b0010, DA5,  1, 4'b0010, 1, 8'hA5, 1, "single ch1 again");
    add(0, 4'b0000, DSEQ, 1, 4'b0000, 0, 8'hA5, 1, "drain holds data");
    add(0, 4'b1000, DSEQ, 1, 4'b1000, 1, 8'h13, 3, "ch3 wraps ptr");
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b1111, DSEQ, 1, 4'b0001, 1, 8'h10, 0, "contention ch0");
      add(0, 4'b1111, DSEQ, 1, 4'b0010, 1, 8'h11, 1, "contention ch1");
      add(0, 4'b1111, DSEQ, 1, 4'b0100, 1, 8'h12, 2, "contention ch2");
      add(0, 4'b1111, DSEQ, 1, 4'b1000, 1, 8'h13, 3, "contention ch3");
    end
    add(0, 4'b1111, DSEQ, 1, 4'b0001, 1, 8'h10, 0, "pre-stall ch0");
    add(0, 4'b1111, DSEQ, 1, 4'b0010, 1, 8'h11, 1, "pre-stall ch1");
    add(0, 4'b1111, DSEQ, 1, 4'b0100, 1, 8'h12, 2, "pre-stall ch2");
    for (int s = 0; s < 5; s++)
      add(0, 4'b1111, DSEQ, 0, 4'b0000, 1, 8'h12, 2, "stall");
    add(0, 4'b1111, DSEQ, 1, 4'b1000, 1, 8'h13, 3, "drain+load ch3");
    add(0, 4'b0100, DSEQ, 1, 4'b0100, 1, 8'h12, 2, "set ptr3");
    add(0, 4'b0101, DSEQ, 1, 4'b0001, 1, 8'h10, 0, "wrap ch0");
    add(0, 4'b0101, DSEQ, 1, 4'b0100, 1, 8'h12, 2, "skip to ch2");
    add(0, 4'b0101, DSEQ, 1, 4'b0001, 1, 8'h10, 0, "wrap ch0 again");
    add(0, 4'b0000, DSEQ, 1, 4'b0000, 0, 8'h10, 0, "idle drain");
    add(0, 4'b0010, DSEQ, 0, 4'b0010, 1, 8'h11, 1, "load when empty");
    add(0, 4'b0010, DSEQ, 0, 4'b0000, 1, 8'h11, 1, "stall held");
    add(1, 4'b1111, DSEQ, 0, 4'b0000, 0, 8'h00, 0, "reset mid-stall");
    add(0, 4'b1111, DSEQ, 1, 4'b0001, 1, 8'h10, 0, "post-reset ptr0");
    add(0, 4'b1110, DSEQ, 1, 4'b0010, 1, 8'h11, 1, "post-reset ch1");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv;
      in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1 check({vecs[i].name, " in_ready"}, {28'd0, in_ready}, {28'd0, vecs[i].e_ir});
      @(posedge clk); #1;
      check({vecs[i].name, " outs"}, {23'd0, out_valid, out_data, out_ch},
            {23'd0, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_och});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
